// File: rtl/mod_arith_pkg.sv
// Shared constant helpers for the mod_* residue-arithmetic blocks.
// Contents:
//   pow2_mod(k, m)       : 2^k mod m, evaluated at elaboration time
//   n_chunks(w, chunk)   : number of chunk slices needed to cover a w-bit operand
//   n_parts(w, chunk)    : number of chunk-by-chunk partial products
//   sum_width(w, chunk)  : width that holds the sum of all reduced partials
package mod_arith_pkg;

    function automatic int pow2_mod(input int k, input int m);
        int r;
        r = 1 % m;
        for (int i = 0; i < k; i++) begin
            r = (r * 2) % m;
        end
        return r;
    endfunction

    function automatic int n_chunks(input int w, input int chunk);
        return (w + chunk - 1) / chunk;
    endfunction

    function automatic int n_parts(input int w, input int chunk);
        return n_chunks(w, chunk) * n_chunks(w, chunk);
    endfunction

    // Each partial is < 2^w, so the sum of n_parts of them needs
    // ceil(log2(n_parts)) extra bits.
    function automatic int sum_width(input int w, input int chunk);
        return w + $clog2(n_parts(w, chunk));
    endfunction

endpackage

// File: rtl/mult_mod_pipe_if.sv
// Stream interface of the pipelined modular multiplier.
// Operand side : in_valid/in_ready handshake, in_a, in_b, in_tag.
// Result side  : out_valid/out_ready handshake, out_r, out_tag, out_err.
// Modports:
//   master : the environment (drives operands and out_ready)
//   slave  : the multiplier (drives in_ready and the result)
interface mult_mod_pipe_if #(
    parameter int W     = 7,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_r, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_tag, out_err
    );
endinterface

// File: rtl/mod_chunk_mult.sv
// Combinational chunk multiplier: r = (a * b * 2^K) mod MOD.
// The product of two CHUNK-bit slices indexes a constant table whose entries
// are already scaled by the slice weight and reduced, so the hardware performs
// no arithmetic against the modulus.
// Ports:
//   a, b : CHUNK-bit operand slices
//   r    : W-bit reduced partial product, always < MOD
module mod_chunk_mult
    import mod_arith_pkg::*;
#(
    parameter int W     = 7,
    parameter int MOD   = 107,
    parameter int CHUNK = 3,
    parameter int K     = 0
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [W-1:0]     r
);
    localparam int NPROD = 1 << (2 * CHUNK);
    localparam int SCALE = pow2_mod(K, MOD);

    logic [2*CHUNK-1:0] prod;
    logic [W-1:0]       tab [NPROD];

    assign prod = {{CHUNK{1'b0}}, a} * {{CHUNK{1'b0}}, b};

    for (genvar p = 0; p < NPROD; p++) begin : g_tab
        assign tab[p] = W'(((p % MOD) * SCALE) % MOD);
    end

    assign r = tab[prod];
endmodule

// File: rtl/mult_mod_pipe.sv
// Pipelined modular multiplier R = (A*B) mod MOD, four register stages.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears valids and result outputs)
//   bus : operand/result streams with valid/ready and a pass-through tag;
//         out_err flags an operand >= MOD (the result is still exact)
// A single advance signal stalls every stage together whenever the output
// holds a result that downstream has not taken.
module mult_mod_pipe
    import mod_arith_pkg::*;
#(
    parameter int W     = 7,
    parameter int MOD   = 107,
    parameter int CHUNK = 3,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    mult_mod_pipe_if.slave bus
);
    localparam int NCH   = n_chunks(W, CHUNK);
    localparam int NPART = n_parts(W, CHUNK);
    localparam int SUM_W = sum_width(W, CHUNK);
    localparam int HI_W  = SUM_W - W;
    localparam int PAD_W = NCH * CHUNK;
    // With 2^(W-1) < MOD < 2^W this equals 2^W - MOD.
    localparam int P2W   = pow2_mod(W, MOD);

    // v < 2^W + MOD; removing bit W and adding 2^W mod MOD is v - MOD,
    // which leaves a value below 2^W and therefore below 2*MOD.
    function automatic logic [W-1:0] fold_top(input logic [W:0] v);
        return v[W-1:0] + (v[W] ? W'(P2W) : W'(0));
    endfunction

    function automatic logic [W-1:0] cond_sub(input logic [W-1:0] v);
        return (v >= W'(MOD)) ? v - W'(MOD) : v;
    endfunction

    logic adv;
    logic vld_p1, vld_p2, vld_p3, vld_p4;

    logic [PAD_W-1:0] a_s0, b_s0;
    logic [W-1:0]     part_s0 [NPART];
    logic             err_s0;

    logic [W-1:0]     part_p1 [NPART];
    logic [TAG_W-1:0] tag_p1, tag_p2, tag_p3, tag_p4;
    logic             err_p1, err_p2, err_p3, err_p4;
    logic [SUM_W-1:0] sum_s1, sum_p2;
    logic [W:0]       fold1_s2;
    logic [W-1:0]     fold_tab [1 << HI_W];
    logic [W-1:0]     fold_p3;
    logic [W-1:0]     r_p4;

    assign adv          = !vld_p4 || bus.out_ready;
    assign bus.in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            vld_p4 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= bus.in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            vld_p4 <= vld_p3;
        end
    end

    // ---- stage 1: slice operands, reduced chunk partial products ----
    assign a_s0   = PAD_W'(bus.in_a);
    assign b_s0   = PAD_W'(bus.in_b);
    assign err_s0 = (bus.in_a >= W'(MOD)) || (bus.in_b >= W'(MOD));

    for (genvar i = 0; i < NCH; i++) begin : g_row
        for (genvar j = 0; j < NCH; j++) begin : g_col
            mod_chunk_mult #(
                .W    (W),
                .MOD  (MOD),
                .CHUNK(CHUNK),
                .K    (CHUNK * (i + j))
            ) u_chunk (
                .a(a_s0[i*CHUNK +: CHUNK]),
                .b(b_s0[j*CHUNK +: CHUNK]),
                .r(part_s0[i*NCH + j])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (adv && bus.in_valid) begin
            for (int k = 0; k < NPART; k++) begin
                part_p1[k] <= part_s0[k];
            end
            tag_p1 <= bus.in_tag;
            err_p1 <= err_s0;
        end
    end

    // ---- stage 2: sum of reduced partials ----
    always_comb begin
        sum_s1 = '0;
        for (int k = 0; k < NPART; k++) begin
            sum_s1 = sum_s1 + SUM_W'(part_p1[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (adv && vld_p1) begin
            sum_p2 <= sum_s1;
            tag_p2 <= tag_p1;
            err_p2 <= err_p1;
        end
    end

    // ---- stage 3: fold bits above W back into range (two folds) ----
    for (genvar h = 0; h < (1 << HI_W); h++) begin : g_fold
        assign fold_tab[h] = W'((h * P2W) % MOD);
    end

    assign fold1_s2 = {1'b0, sum_p2[W-1:0]} + {1'b0, fold_tab[sum_p2[SUM_W-1:W]]};

    always_ff @(posedge clk) begin
        if (adv && vld_p2) begin
            fold_p3 <= fold_top(fold1_s2);
            tag_p3  <= tag_p2;
            err_p3  <= err_p2;
        end
    end

    // ---- stage 4: final conditional subtract into the output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p4   <= '0;
            tag_p4 <= '0;
            err_p4 <= 1'b0;
        end else if (adv && vld_p3) begin
            r_p4   <= cond_sub(fold_p3);
            tag_p4 <= tag_p3;
            err_p4 <= err_p3;
        end
    end

    assign bus.out_valid = vld_p4;
    assign bus.out_r     = r_p4;
    assign bus.out_tag   = tag_p4;
    assign bus.out_err   = err_p4;
endmodule

// File: tb/tb_mult_mod_pipe.sv
`timescale 1ns/1ps
module tb_mult_mod_pipe;
    localparam int W      = 7;
    localparam int MOD    = 107;
    localparam int CHUNK  = 3;
    localparam int TAG_W  = 4;
    localparam int W2     = 8;
    localparam int MOD2   = 251;
    localparam int CHUNK2 = 4;
    localparam int NOPS   = 10000;

    typedef struct {
        int r;
        int tag;
        int err;
    } exp_t;

    typedef struct {
        int a;
        int b;
        int tag;
        int r;
        int err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    mult_mod_pipe_if #(.W(W),  .TAG_W(TAG_W)) bus  ();
    mult_mod_pipe_if #(.W(W2), .TAG_W(TAG_W)) bus2 ();

    mult_mod_pipe #(.W(W), .MOD(MOD), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    mult_mod_pipe #(.W(W2), .MOD(MOD2), .CHUNK(CHUNK2), .TAG_W(TAG_W)) dut2 (
        .clk(clk),
        .rst(rst2),
        .bus(bus2)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q1[$];
    exp_t q2[$];
    vec_t vecs[6];
    int   pat[12];
    bit   ov[12];
    bit   done2 = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definition.
    function automatic exp_t model(input int a, input int b, input int tag, input int m);
        exp_t e;
        e.r   = (a * b) % m;
        e.tag = tag;
        e.err = (a >= m || b >= m) ? 1 : 0;
        return e;
    endfunction

    // Operand generator biased toward the interesting edges.
    function automatic int pick(input int maxv, input int m);
        int s;
        s = int'($urandom_range(0, 7));
        case (s)
            0:       return 0;
            1:       return m - 1;
            2:       return m;
            3:       return maxv;
            default: return int'($urandom_range(0, maxv));
        endcase
    endfunction

    // One clock of stimulus on the W=7 instance with scoreboard checking.
    task automatic step(input bit v, input int a, input int b, input int tag,
                        input bit ordy, output bit xfer);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = W'(a);
        bus.in_b      = W'(b);
        bus.in_tag    = TAG_W'(tag);
        bus.out_ready = ordy;
        #1;
        check("in_ready", int'(bus.in_ready), int'(ordy || !bus.out_valid));
        if (q1.size() == 0) begin
            check("unexpected_out_valid", int'(bus.out_valid), 0);
        end else if (bus.out_valid) begin
            e = q1[0];
            check("out_r",   int'(bus.out_r),   e.r);
            check("out_tag", int'(bus.out_tag), e.tag);
            check("out_err", int'(bus.out_err), e.err);
            if (ordy) void'(q1.pop_front());
        end
        xfer = v && bus.in_ready;
        if (xfer) q1.push_back(model(a, b, tag, MOD));
    endtask

    initial begin
        int lat;
        int k;
        int cyc;
        int sent;
        bit xf;
        bit ordy;
        bit v;

        vecs[0] = '{106, 106, 1, 1,   0};
        vecs[1] = '{0,   55,  2, 0,   0};
        vecs[2] = '{1,   106, 3, 106, 0};
        vecs[3] = '{100, 50,  4, 78,  0};
        vecs[4] = '{127, 127, 5, 79,  1};
        vecs[5] = '{107, 2,   6, 0,   1};
        pat = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_r",     int'(bus.out_r),     0);
        check("rst_out_tag",   int'(bus.out_tag),   0);
        check("rst_out_err",   int'(bus.out_err),   0);
        check("rst_in_ready",  int'(bus.in_ready),  1);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner vectors with latency measurement.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_a      = W'(vecs[i].a);
            bus.in_b      = W'(vecs[i].b);
            bus.in_tag    = TAG_W'(vecs[i].tag);
            bus.out_ready = 1'b1;
            lat = 0;
            for (int n = 1; n <= 10; n++) begin
                @(posedge clk);
                #1;
                if (n == 1) bus.in_valid = 1'b0;
                if (bus.out_valid) begin
                    lat = n;
                    break;
                end
            end
            check("vec_latency", lat, 4);
            check("vec_out_r",   int'(bus.out_r),   vecs[i].r);
            check("vec_out_err", int'(bus.out_err), vecs[i].err);
            check("vec_out_tag", int'(bus.out_tag), vecs[i].tag);
            @(posedge clk);
        end
        repeat (3) @(posedge clk);

        // Bubbles: out_valid must replay the in_valid pattern 4 cycles later.
        for (int c = 0; c < 12; c++) begin
            step(pat[c] != 0, pick(127, MOD), pick(127, MOD), c, 1'b1, xf);
            ov[c] = bus.out_valid;
        end
        for (int c = 0; c < 4; c++) check("bubble_lead", int'(ov[c]), 0);
        for (int c = 0; c < 8; c++) check("bubble_shift", int'(ov[c + 4]), pat[c]);

        // Backpressure: 8 tagged ops, downstream not ready in cycles 3..7.
        k = 0;
        cyc = 0;
        while ((k < 8 || q1.size() > 0) && cyc < 60) begin
            ordy = !(cyc >= 3 && cyc <= 7);
            step(k < 8, pick(127, MOD), pick(127, MOD), k, ordy, xf);
            if (!ordy && bus.out_valid) check("stall_in_ready", int'(bus.in_ready), 0);
            if (xf) k++;
            cyc++;
        end
        check("bp_drained", int'(k == 8 && q1.size() == 0), 1);

        // Reset in the middle of a stream: nothing stale may emerge.
        for (int c = 0; c < 6; c++) step(1'b1, pick(127, MOD), pick(127, MOD), c, 1'b1, xf);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_r",     int'(bus.out_r),     0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        q1.delete();
        #1;
        check("midrst_in_ready", int'(bus.in_ready), 1);
        for (int c = 0; c < 10; c++) step(1'b0, 0, 0, 0, 1'b1, xf);

        // Random traffic with random downstream readiness.
        sent = 0;
        cyc = 0;
        while ((sent < NOPS || q1.size() > 0) && cyc < 40000) begin
            v    = (sent < NOPS) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(v, pick(127, MOD), pick(127, MOD), int'($urandom_range(0, 15)), ordy, xf);
            if (xf) sent++;
            cyc++;
        end
        check("rand_drained", int'(sent == NOPS && q1.size() == 0), 1);

        for (int i = 0; i < 50000 && !done2; i++) @(posedge clk);
        check("dut2_done", int'(done2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Second configuration (W=8, MOD=251, CHUNK=4) under random traffic.
    initial begin
        int   sent2;
        int   cyc2;
        int   a;
        int   b;
        int   tag;
        bit   v2;
        bit   ordy2;
        exp_t e;

        bus2.in_valid  = 1'b0;
        bus2.in_a      = '0;
        bus2.in_b      = '0;
        bus2.in_tag    = '0;
        bus2.out_ready = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        sent2 = 0;
        cyc2 = 0;
        while ((sent2 < NOPS || q2.size() > 0) && cyc2 < 40000) begin
            @(negedge clk);
            v2    = (sent2 < NOPS) && ($urandom_range(0, 3) != 0);
            ordy2 = ($urandom_range(0, 3) != 0);
            a     = pick(255, MOD2);
            b     = pick(255, MOD2);
            tag   = int'($urandom_range(0, 15));
            bus2.in_valid  = v2;
            bus2.in_a      = W2'(a);
            bus2.in_b      = W2'(b);
            bus2.in_tag    = TAG_W'(tag);
            bus2.out_ready = ordy2;
            #1;
            if (q2.size() == 0) begin
                check("w8_unexpected_out_valid", int'(bus2.out_valid), 0);
            end else if (bus2.out_valid) begin
                e = q2[0];
                check("w8_out_r",   int'(bus2.out_r),   e.r);
                check("w8_out_tag", int'(bus2.out_tag), e.tag);
                check("w8_out_err", int'(bus2.out_err), e.err);
                if (ordy2) void'(q2.pop_front());
            end
            if (v2 && bus2.in_ready) begin
                q2.push_back(model(a, b, tag, MOD2));
                sent2++;
            end
            cyc2++;
        end
        check("w8_drained", int'(sent2 == NOPS && q2.size() == 0), 1);
        done2 = 1'b1;
    end
endmodule
